pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Sequences the SWIR clock-generation PLL from power-up to a usable, stable lock. It drives the PLL reset, synchronises and qualifies the PLL `locked` output, and releases downstream clock-domain resets one domain at a time. It detects loss of lock, retries, and escalates to a fault after repeated failures. It runs on the free-running 50 MHz reference clock that also feeds the PLL.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before the attempt fails (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release (>=1).
- NUM_DOMAINS, 4: number of downstream domain resets (1..8).
- RELEASE_GAP, 8: cycles between successive domain reset releases (>=1).
- MAX_RETRIES, 3: failed attempts allowed before FAULT (1..15).

Ports:
- clock  in  1  50 MHz reference clock (same net as PLL refclk).
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked output, asynchronous to clock.
- relock_req  in  1  single-cycle request to re-run the lock sequence.
- pll_rst  out  1  active-high PLL reset.
- domain_rst_n  out  NUM_DOMAINS  active-low resets for downstream domains.
- ready  out  1  high only in RUNNING.
- fault  out  1  high only in FAULT.
- retry_count  out  4  failed attempts in the current sequence.
- state_dbg  out  3  encoded state: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RELEASE=3, RUNNING=4, FAULT=5.

Behaviour:
- Clock/reset:
  - Single clock `clock`; reset `reset_n` is asynchronous and active-low.
  - All outputs are registered.
- Reset values:
  - state = RESET_PLL, pll_rst = 1, domain_rst_n = all 0.
  - ready = 0, fault = 0, retry_count = 0, internal timer = 0.
- Lock synchroniser:
  - pll_locked passes through a 2-flop synchroniser to give lock_s.
  - lock_s reflects a pin change 2 cycles later; FSM output changes land 1 further edge later.
- RESET_PLL:
  - pll_rst = 1 and domain_rst_n = 0.
  - After PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK; pll_rst = 0 from that edge.
- WAIT_LOCK:
  - lock_s = 1 → STABILIZE, timer cleared.
  - LOCK_TIMEOUT cycles elapse without lock → failed attempt.
- STABILIZE:
  - lock_s must stay 1 for STABLE_CYCLES consecutive cycles, then go to RELEASE.
  - Any lock_s = 0 → failed attempt.
- Failed attempt:
  - retry_count increments.
  - If the new value equals MAX_RETRIES → FAULT; otherwise → RESET_PLL.
- RELEASE:
  - On the entry edge, domain_rst_n[0] goes to 1.
  - Each following bit i goes to 1 RELEASE_GAP cycles after bit i-1, in ascending index order only.
  - After bit NUM_DOMAINS-1 is released → RUNNING.
- RUNNING:
  - ready = 1; retry_count is cleared on entry.
- Lock loss in RELEASE or RUNNING (lock_s = 0):
  - On the next edge, all domain_rst_n = 0, ready = 0, state = RESET_PLL.
  - Not counted as a retry.
- relock_req:
  - In RUNNING or RELEASE: same action as lock loss.
  - In FAULT: fault = 0, retry_count = 0, → RESET_PLL.
  - In all other states: ignored.
  - Lock loss and relock_req in the same cycle: treated as lock loss.
- FAULT:
  - pll_rst = 1, domain_rst_n = 0, fault = 1.
  - Held until relock_req or reset.
- Timer: one shared counter, cleared on every state transition; width sized for max(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES, RELEASE_GAP).
- Async reset mid-sequence: immediate return to the reset values above.

Optional Feature:
Macro: PLL_LOCK_LOSS_COUNT_EN.
- Defined:
  - Adds output `lock_loss_count`, out, 8 bits, reset value 0.
  - Saturating at 255; increments once per lock-loss event in RELEASE/RUNNING.
  - Does not increment on relock_req or on failed attempts.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, NUM_DOMAINS=3, RELEASE_GAP=2, MAX_RETRIES=2.
- Nominal lock: release reset_n, raise pll_locked 5 cycles after pll_rst falls.
  - pll_rst high for exactly 4 cycles.
  - STABILIZE lasts 8 cycles.
  - domain_rst_n goes 001 → 011 → 111 at 2-cycle spacing.
  - ready = 1 with domain_rst_n = 111; retry_count = 0.
- Timeout escalation: keep pll_locked = 0.
  - Two WAIT_LOCK periods of 20 cycles each, separated by a 4-cycle pll_rst pulse.
  - Then fault = 1, retry_count = 2, state_dbg = 5, pll_rst = 1.
  - A relock_req pulse gives fault = 0, retry_count = 0, state_dbg = 0.
- Glitch during STABILIZE: drop pll_locked for 1 cycle after 5 stable cycles.
  - retry_count = 1, state back to RESET_PLL, no domain released.
  - A clean second attempt reaches RUNNING with retry_count = 0.
- Lock loss in RUNNING: drop pll_locked.
  - Exactly 3 cycles later, domain_rst_n = 000, ready = 0, pll_rst = 1.
  - lock_loss_count = 1 when PLL_LOCK_LOSS_COUNT_EN is defined.
- relock_req in RUNNING: domains reset and the sequence restarts; lock_loss_count unchanged.
  - Same scenario with pll_locked falling in the same cycle as relock_req: counter increments.
- Async reset: assert reset_n mid-RELEASE (domain_rst_n = 011).
  - Outputs return to reset values with no clock edge; the sequence restarts cleanly after deassertion.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer, the PLL and the downstream domains.
// lock_loss_count is present only when PLL_LOCK_LOSS_COUNT_EN is defined.
interface pll_lock_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   pll_locked;
    logic                   relock_req;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   ready;
    logic                   fault;
    logic [3:0]             retry_count;
    logic [2:0]             state_dbg;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0]             lock_loss_count;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, domain_rst_n, ready, fault, retry_count, state_dbg, lock_loss_count
    );
    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, domain_rst_n, ready, fault, retry_count, state_dbg, lock_loss_count
    );
`else
    modport master (
        input  pll_locked, relock_req,
        output pll_rst, domain_rst_n, ready, fault, retry_count, state_dbg
    );
    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, domain_rst_n, ready, fault, retry_count, state_dbg
    );
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: resets the PLL, qualifies lock, releases domain resets in order,
// retries on failure and escalates to FAULT. Optional lock-loss counter: PLL_LOCK_LOSS_COUNT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET_PLL | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | waiting for synchronised lock, bounded by LOCK_TIMEOUT
// STABILIZE | lock must stay high for STABLE_CYCLES consecutive cycles
// RELEASE   | domain resets released one by one, RELEASE_GAP apart
// RUNNING   | all domains out of reset, ready high
// FAULT     | too many failed attempts, PLL held in reset until relock_req
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_DOMAINS    = 4,
    parameter int RELEASE_GAP    = 8,
    parameter int MAX_RETRIES    = 3
) (
    input logic                  clock,
    input logic                  reset_n,
    pll_lock_sequencer_if.master bus
);
    localparam int T_A   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int T_B   = (PLL_RST_CYCLES > RELEASE_GAP) ? PLL_RST_CYCLES : RELEASE_GAP;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] RST_TC     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_TC = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_TC  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_TC     = TW'(RELEASE_GAP - 1);
    localparam logic [3:0]    MAX_TC     = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RELEASE   = 3'd3,
        RUNNING   = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t                 state, state_nxt;
    logic [TW-1:0]          timer, timer_nxt;
    logic [NUM_DOMAINS-1:0] dom_q, dom_nxt;
    logic [3:0]             retry_q, retry_nxt;
    logic                   sync1, lock_s;
    logic                   pll_rst_q, ready_q, fault_q;
    logic                   fail, restart, lock_loss;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        dom_nxt   = dom_q;
        retry_nxt = retry_q;
        fail      = 1'b0;
        restart   = 1'b0;
        lock_loss = 1'b0;
        case (state)
            RESET_PLL: begin
                timer_nxt = timer + 1'b1;
                if (timer == RST_TC) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                timer_nxt = timer + 1'b1;
                if (lock_s) state_nxt = STABILIZE;
                else if (timer == TIMEOUT_TC) fail = 1'b1;
            end
            STABILIZE: begin
                timer_nxt = timer + 1'b1;
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (timer == STABLE_TC) begin
                    state_nxt = RELEASE;
                    dom_nxt   = NUM_DOMAINS'(1);
                end
            end
            RELEASE: begin
                timer_nxt = timer + 1'b1;
                if (!lock_s) begin
                    lock_loss = 1'b1;
                end else if (bus.relock_req) begin
                    restart = 1'b1;
                end else if (timer == GAP_TC) begin
                    // Thermometer growth keeps releases strictly in ascending index order.
                    timer_nxt = '0;
                    dom_nxt   = dom_q | (dom_q << 1);
                    if (&dom_nxt) state_nxt = RUNNING;
                end
            end
            RUNNING: begin
                if (!lock_s) lock_loss = 1'b1;
                else if (bus.relock_req) restart = 1'b1;
            end
            FAULT: begin
                if (bus.relock_req) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = RESET_PLL;
        endcase

        if (fail) begin
            retry_nxt = retry_q + 1'b1;
            state_nxt = (retry_nxt == MAX_TC) ? FAULT : RESET_PLL;
        end
        if (lock_loss || restart) begin
            state_nxt = RESET_PLL;
            dom_nxt   = '0;
        end
        if (state_nxt == RUNNING) retry_nxt = '0;
        if (state_nxt != state) timer_nxt = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            lock_s    <= 1'b0;
            state     <= RESET_PLL;
            timer     <= '0;
            dom_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            sync1     <= bus.pll_locked;
            lock_s    <= sync1;
            state     <= state_nxt;
            timer     <= timer_nxt;
            dom_q     <= dom_nxt;
            retry_q   <= retry_nxt;
            pll_rst_q <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
            ready_q   <= (state_nxt == RUNNING);
            fault_q   <= (state_nxt == FAULT);
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.domain_rst_n = dom_q;
    assign bus.ready        = ready_q;
    assign bus.fault        = fault_q;
    assign bus.retry_count  = retry_q;
    assign bus.state_dbg    = state;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] loss_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt <= '0;
        end else if (lock_loss && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign bus.lock_loss_count = loss_cnt;
`endif
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios with literal expectations plus
// randomized lock/relock/reset stimulus compared every cycle against a phase/age model.
module tb_pll_lock_sequencer;
    localparam int PRC = 4;
    localparam int LTO = 20;
    localparam int STC = 8;
    localparam int ND  = 3;
    localparam int GAP = 2;
    localparam int MR  = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   n;
    int   hold;

    pll_lock_sequencer_if #(.NUM_DOMAINS(ND)) bus();

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .STABLE_CYCLES (STC),
        .NUM_DOMAINS   (ND),
        .RELEASE_GAP   (GAP),
        .MAX_RETRIES   (MR)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase number, cycles spent in the phase, and the pin seen two edges ago.
    int m_ph, m_age, m_retry, m_llc, m_nph;
    bit m_s1, m_s2, m_ls, m_fail;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ph = 0; m_age = 0; m_retry = 0; m_llc = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            m_ls   = m_s2;
            m_nph  = m_ph;
            m_fail = 0;
            case (m_ph)
                0: if (m_age + 1 == PRC) m_nph = 1;
                1: if (m_ls) m_nph = 2; else if (m_age + 1 == LTO) m_fail = 1;
                2: if (!m_ls) m_fail = 1; else if (m_age + 1 == STC) m_nph = 3;
                3, 4: begin
                    if (!m_ls) begin
                        m_nph = 0;
                        if (m_llc < 255) m_llc++;
                    end else if (bus.relock_req) begin
                        m_nph = 0;
                    end else if (m_ph == 3 && m_age + 1 == (ND - 1) * GAP) begin
                        m_nph = 4;
                    end
                end
                5: if (bus.relock_req) begin m_nph = 0; m_retry = 0; end
                default: ;
            endcase
            if (m_fail) begin
                m_retry++;
                m_nph = (m_retry == MR) ? 5 : 0;
            end
            if (m_nph == 4) m_retry = 0;
            m_age = (m_nph == m_ph) ? m_age + 1 : 0;
            m_ph  = m_nph;
            m_s2  = m_s1;
            m_s1  = bus.pll_locked;
        end
    end

    function automatic int exp_dom();
        int k = 0;
        int v = 0;
        if (m_ph == 4) k = ND;
        else if (m_ph == 3) k = 1 + m_age / GAP;
        if (k > ND) k = ND;
        for (int i = 0; i < k; i++) v = v | (1 << i);
        return v;
    endfunction

    always @(negedge clock) begin
        chk("m_state",   int'(bus.state_dbg),    m_ph);
        chk("m_pll_rst", int'(bus.pll_rst),      int'(m_ph == 0 || m_ph == 5));
        chk("m_dom",     int'(bus.domain_rst_n), exp_dom());
        chk("m_ready",   int'(bus.ready),        int'(m_ph == 4));
        chk("m_fault",   int'(bus.fault),        int'(m_ph == 5));
        chk("m_retry",   int'(bus.retry_count),  m_retry);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("m_llc",     int'(bus.lock_loss_count), m_llc);
`endif
    end

    task automatic wait_state(input int s, input int budget, input string nm);
        int k = 0;
        while (int'(bus.state_dbg) != s && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (int'(bus.state_dbg) != s) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, state %0d required %0d", nm, bus.state_dbg, s);
        end
    endtask

    task automatic count_state(input int s, output int k);
        k = 0;
        while (int'(bus.state_dbg) == s && k < 1000) begin
            k++;
            @(negedge clock);
        end
    endtask

    task automatic relock_pulse();
        bus.relock_req = 1'b1;
        @(negedge clock);
        bus.relock_req = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_state"},   int'(bus.state_dbg),    0);
        chk({nm, "_pll_rst"}, int'(bus.pll_rst),      1);
        chk({nm, "_dom"},     int'(bus.domain_rst_n), 0);
        chk({nm, "_ready"},   int'(bus.ready),        0);
        chk({nm, "_fault"},   int'(bus.fault),        0);
        chk({nm, "_retry"},   int'(bus.retry_count),  0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk({nm, "_llc"},     int'(bus.lock_loss_count), 0);
`endif
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_vals("rst");
        reset_n = 1'b1;

        // Nominal lock
        n = 0;
        while (bus.pll_rst && n < 100) begin n++; @(negedge clock); end
        chk("nom_pll_rst_cycles", n, 4);
        repeat (5) @(negedge clock);
        bus.pll_locked = 1'b1;
        wait_state(2, 40, "nom_reach_stab");
        count_state(2, n);
        chk("nom_stab_cycles", n, 8);
        chk("nom_dom0", int'(bus.domain_rst_n), 1);
        @(negedge clock); chk("nom_dom1", int'(bus.domain_rst_n), 1);
        @(negedge clock); chk("nom_dom2", int'(bus.domain_rst_n), 3);
        @(negedge clock); chk("nom_dom3", int'(bus.domain_rst_n), 3);
        @(negedge clock); chk("nom_dom4", int'(bus.domain_rst_n), 7);
        chk("nom_ready", int'(bus.ready), 1);
        chk("nom_retry", int'(bus.retry_count), 0);
        chk("nom_state", int'(bus.state_dbg), 4);

        // Lock loss in RUNNING
        repeat (3) @(negedge clock);
        bus.pll_locked = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (bus.domain_rst_n != 0 && n < 20);
        chk("loss_latency", n, 3);
        chk("loss_ready", int'(bus.ready), 0);
        chk("loss_pll_rst", int'(bus.pll_rst), 1);
        chk("loss_retry", int'(bus.retry_count), 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("loss_llc", int'(bus.lock_loss_count), 1);
`endif

        // Timeout escalation
        wait_state(1, 20, "to_reach_wait1");
        count_state(1, n);
        chk("to_wait1_cycles", n, 20);
        chk("to_retry1", int'(bus.retry_count), 1);
        n = 0;
        while (bus.pll_rst && n < 100) begin n++; @(negedge clock); end
        chk("to_pll_rst_cycles", n, 4);
        count_state(1, n);
        chk("to_wait2_cycles", n, 20);
        chk("to_state", int'(bus.state_dbg), 5);
        chk("to_fault", int'(bus.fault), 1);
        chk("to_retry2", int'(bus.retry_count), 2);
        chk("to_pll_rst", int'(bus.pll_rst), 1);
        repeat (5) @(negedge clock);
        chk("to_fault_held", int'(bus.state_dbg), 5);
        relock_pulse();
        chk("to_relock_state", int'(bus.state_dbg), 0);
        chk("to_relock_fault", int'(bus.fault), 0);
        chk("to_relock_retry", int'(bus.retry_count), 0);

        // Glitch during STABILIZE
        bus.pll_locked = 1'b1;
        wait_state(2, 40, "gl_reach_stab");
        repeat (3) @(negedge clock);
        bus.pll_locked = 1'b0;
        @(negedge clock);
        bus.pll_locked = 1'b1;
        wait_state(0, 20, "gl_back_reset");
        chk("gl_retry", int'(bus.retry_count), 1);
        chk("gl_dom", int'(bus.domain_rst_n), 0);
        wait_state(4, 100, "gl_second_attempt");
        chk("gl_run_retry", int'(bus.retry_count), 0);
        chk("gl_run_dom", int'(bus.domain_rst_n), 7);

        // relock_req in RUNNING
        repeat (2) @(negedge clock);
        relock_pulse();
        chk("rl_state", int'(bus.state_dbg), 0);
        chk("rl_dom", int'(bus.domain_rst_n), 0);
        chk("rl_ready", int'(bus.ready), 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("rl_llc", int'(bus.lock_loss_count), 1);
`endif
        wait_state(4, 100, "rl_rerun");

        // relock_req in the cycle the synchronised lock drops: counted as lock loss
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge clock);
        relock_pulse();
        chk("rlx_state", int'(bus.state_dbg), 0);
        chk("rlx_dom", int'(bus.domain_rst_n), 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("rlx_llc", int'(bus.lock_loss_count), 2);
`endif

        // Async reset mid-RELEASE
        bus.pll_locked = 1'b1;
        n = 0;
        while (bus.domain_rst_n != 3'b011 && n < 100) begin @(negedge clock); n++; end
        chk("ar_reach_011", int'(bus.domain_rst_n), 3);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("ar");
        @(negedge clock);
        reset_n = 1'b1;
        wait_state(4, 100, "ar_restart");
        chk("ar_run_dom", int'(bus.domain_rst_n), 7);
        chk("ar_run_ready", int'(bus.ready), 1);

        // Randomized lock behaviour, relock requests and occasional resets
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (hold == 0) begin
                bus.pll_locked = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end else begin
                hold--;
            end
            bus.relock_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end
        @(negedge clock);
        bus.relock_req = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
